// File: rtl/snoop_bcast_ctrl.sv
// Snoop broadcast controller: forks one upstream AC snoop to NumMst masters,
// merges their CR responses and forwards CD data from a single winning master.

package snoop_pkg;
    typedef logic [3:0] acsnoop_t;
    typedef logic [2:0] acprot_t;
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;
endpackage

module snoop_bcast_ctrl
    import snoop_pkg::*;
#(
    parameter int NumMst    = 2,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ac_valid_i,
    output logic                             ac_ready_o,
    input  logic [AddrWidth-1:0]             ac_addr_i,
    input  acsnoop_t                         ac_snoop_i,
    input  acprot_t                          ac_prot_i,
    output logic                             cr_valid_o,
    input  logic                             cr_ready_i,
    output crresp_t                          cr_resp_o,
    output logic                             cd_valid_o,
    input  logic                             cd_ready_i,
    output logic [DataWidth-1:0]             cd_data_o,
    output logic                             cd_last_o,
    output logic [NumMst-1:0]                mst_ac_valid_o,
    input  logic [NumMst-1:0]                mst_ac_ready_i,
    output logic [AddrWidth-1:0]             mst_ac_addr_o,
    output acsnoop_t                         mst_ac_snoop_o,
    output acprot_t                          mst_ac_prot_o,
    input  logic [NumMst-1:0]                mst_cr_valid_i,
    output logic [NumMst-1:0]                mst_cr_ready_o,
    input  crresp_t [NumMst-1:0]             mst_cr_resp_i,
    input  logic [NumMst-1:0]                mst_cd_valid_i,
    output logic [NumMst-1:0]                mst_cd_ready_o,
    input  logic [NumMst-1:0][DataWidth-1:0] mst_cd_data_i,
    input  logic [NumMst-1:0]                mst_cd_last_i
);

    localparam int IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        RESP  = 2'd2,
        DATA  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [NumMst-1:0]        ac_pend_q, ac_pend_d;
    logic [NumMst-1:0]        cr_pend_q, cr_pend_d;
    logic [NumMst-1:0]        cd_pend_q, cd_pend_d;
    logic [AddrWidth-1:0]     addr_q, addr_d;
    acsnoop_t                 snoop_q, snoop_d;
    acprot_t                  prot_q, prot_d;
    crresp_t [NumMst-1:0]     resp_q, resp_d;
    crresp_t                  cr_resp_q, cr_resp_d;
    logic [IdxW-1:0]          win_q, win_d;
    crresp_t                  merged_s;
    logic [IdxW-1:0]          win_pd_s, win_dt_s;
    logic                     have_pd_s;
    logic [NumMst-1:0]        dt_s;

    // Next-state, handshake bookkeeping and all handshake outputs.
    always_comb begin
        state_d        = state_q;
        ac_pend_d      = ac_pend_q;
        cr_pend_d      = cr_pend_q;
        cd_pend_d      = cd_pend_q;
        addr_d         = addr_q;
        snoop_d        = snoop_q;
        prot_d         = prot_q;
        resp_d         = resp_q;
        cr_resp_d      = cr_resp_q;
        win_d          = win_q;
        ac_ready_o     = 1'b0;
        cr_valid_o     = 1'b0;
        cd_valid_o     = 1'b0;
        cd_data_o      = {DataWidth{1'b0}};
        cd_last_o      = 1'b0;
        mst_ac_valid_o = {NumMst{1'b0}};
        mst_cr_ready_o = {NumMst{1'b0}};
        mst_cd_ready_o = {NumMst{1'b0}};
        merged_s       = '0;
        win_pd_s       = {IdxW{1'b0}};
        win_dt_s       = {IdxW{1'b0}};
        have_pd_s      = 1'b0;
        dt_s           = {NumMst{1'b0}};

        case (state_q)
            IDLE: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) begin
                    addr_d    = ac_addr_i;
                    snoop_d   = ac_snoop_i;
                    prot_d    = ac_prot_i;
                    ac_pend_d = {NumMst{1'b1}};
                    cr_pend_d = {NumMst{1'b1}};
                    state_d   = SNOOP;
                end else begin
                    state_d = IDLE;
                end
            end
            SNOOP: begin
                mst_ac_valid_o = ac_pend_q;
                mst_cr_ready_o = cr_pend_q & ~ac_pend_q;
                for (int i = 0; i < NumMst; i++) begin
                    if (ac_pend_q[i] && mst_ac_ready_i[i]) begin
                        ac_pend_d[i] = 1'b0;
                    end else begin
                        ac_pend_d[i] = ac_pend_q[i];
                    end
                    if (mst_cr_ready_o[i] && mst_cr_valid_i[i]) begin
                        resp_d[i]    = mst_cr_resp_i[i];
                        cr_pend_d[i] = 1'b0;
                    end else begin
                        cr_pend_d[i] = cr_pend_q[i];
                    end
                end
                // Merge and pick the winner from the just-completed responses so
                // cr_valid_o can rise the cycle after the last CR handshake.
                for (int i = NumMst - 1; i >= 0; i--) begin
                    merged_s = crresp_t'(merged_s | resp_d[i]);
                    dt_s[i]  = resp_d[i].data_transfer;
                    if (resp_d[i].data_transfer && resp_d[i].pass_dirty) begin
                        win_pd_s  = IdxW'(i);
                        have_pd_s = 1'b1;
                    end else begin
                        have_pd_s = have_pd_s;
                    end
                    if (resp_d[i].data_transfer) begin
                        win_dt_s = IdxW'(i);
                    end else begin
                        win_dt_s = win_dt_s;
                    end
                end
                if ((ac_pend_d == {NumMst{1'b0}}) && (cr_pend_d == {NumMst{1'b0}})) begin
                    cr_resp_d = merged_s;
                    cd_pend_d = dt_s;
                    win_d     = have_pd_s ? win_pd_s : win_dt_s;
                    state_d   = RESP;
                end else begin
                    state_d = SNOOP;
                end
            end
            RESP: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) begin
                    state_d = (cd_pend_q != {NumMst{1'b0}}) ? DATA : IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            DATA: begin
                cd_valid_o = cd_pend_q[win_q] & mst_cd_valid_i[win_q];
                cd_data_o  = mst_cd_data_i[win_q];
                cd_last_o  = mst_cd_last_i[win_q];
                // Losers are drained unconditionally; only the winner sees backpressure.
                for (int i = 0; i < NumMst; i++) begin
                    if (cd_pend_q[i]) begin
                        mst_cd_ready_o[i] = (IdxW'(i) == win_q) ? cd_ready_i : 1'b1;
                    end else begin
                        mst_cd_ready_o[i] = 1'b0;
                    end
                    if (mst_cd_ready_o[i] && mst_cd_valid_i[i] && mst_cd_last_i[i]) begin
                        cd_pend_d[i] = 1'b0;
                    end else begin
                        cd_pend_d[i] = cd_pend_q[i];
                    end
                end
                if (cd_pend_d == {NumMst{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ac_pend_q <= {NumMst{1'b0}};
            cr_pend_q <= {NumMst{1'b0}};
            cd_pend_q <= {NumMst{1'b0}};
            addr_q    <= {AddrWidth{1'b0}};
            snoop_q   <= '0;
            prot_q    <= '0;
            resp_q    <= '0;
            cr_resp_q <= '0;
            win_q     <= {IdxW{1'b0}};
        end else begin
            state_q   <= state_d;
            ac_pend_q <= ac_pend_d;
            cr_pend_q <= cr_pend_d;
            cd_pend_q <= cd_pend_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            prot_q    <= prot_d;
            resp_q    <= resp_d;
            cr_resp_q <= cr_resp_d;
            win_q     <= win_d;
        end
    end

    assign cr_resp_o      = cr_resp_q;
    assign mst_ac_addr_o  = addr_q;
    assign mst_ac_snoop_o = snoop_q;
    assign mst_ac_prot_o  = prot_q;

endmodule
